// File: rtl/ram_pkg.sv
// Shared types and defaults for the DRAM refresh scheduler.
package ram_pkg;

    localparam int unsigned DEBT_W  = 4;
    localparam int unsigned TIMER_W = 16;
    localparam int unsigned AGE_W   = 16;
    localparam int unsigned STAT_W  = 16;

    localparam int unsigned DEF_INTERVAL = 390;
    localparam int unsigned DEF_MAX_DEBT = 4;
    localparam int unsigned DEF_URG_DEBT = 2;
    localparam int unsigned DEF_URG_AGE  = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        URG  = 2'd2
    } refState_t;

    // Maps a debt/age pair onto the request level it demands.
    function automatic refState_t classify(
        input logic [DEBT_W-1:0] debt,
        input logic [AGE_W-1:0]  age,
        input logic [DEBT_W-1:0] urgDebt,
        input logic [AGE_W-1:0]  urgAge
    );
        if (debt == '0) begin
            return IDLE;
        end else if ((debt >= urgDebt) || (age >= urgAge)) begin
            return URG;
        end else begin
            return PEND;
        end
    endfunction

endpackage

// File: rtl/ref_interval_timer.sv
// Free-running reloadable down-counter; pulses Tick_c on the cycle it
// reaches zero and reloads RELOAD on that same edge. Holds while En=0.
module ref_interval_timer #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned RELOAD = 389
) (
    input  logic CLK,
    input  logic nRST,
    input  logic En,
    output logic Tick_c
);

    localparam logic [WIDTH-1:0] RELOAD_V = WIDTH'(RELOAD);

    logic [WIDTH-1:0] count;

    assign Tick_c = En && (count == '0);

    // Count down while enabled, wrapping to the reload value at zero.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= RELOAD_V;
        end else if (En) begin
            if (count == '0) begin
                count <= RELOAD_V;
            end else begin
                count <= count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ram_refresh_sched.sv
// DRAM refresh scheduler: turns a refresh interval timer and an owed-refresh
// debt counter into the RefReq/RefUrg pair for the RAM sequencer.
// Optional build macro REF_STATS_EN adds RefCount (accepted acks, wrapping)
// and MaxDebt (debt high-water mark) outputs.
module ram_refresh_sched
    import ram_pkg::*;
#(
    parameter int unsigned INTERVAL = DEF_INTERVAL,
    parameter int unsigned MAX_DEBT = DEF_MAX_DEBT,
    parameter int unsigned URG_DEBT = DEF_URG_DEBT,
    parameter int unsigned URG_AGE  = DEF_URG_AGE
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              RefEn,
    input  logic              RefAck,
    output logic              RefReq,
    output logic              RefUrg,
    output logic [DEBT_W-1:0] Debt,
`ifdef REF_STATS_EN
    output logic              Overrun,
    output logic [STAT_W-1:0] RefCount,
    output logic [DEBT_W-1:0] MaxDebt
`else
    output logic              Overrun
`endif
);

    localparam logic [DEBT_W-1:0] MAX_D = DEBT_W'(MAX_DEBT);
    localparam logic [DEBT_W-1:0] URG_D = DEBT_W'(URG_DEBT);
    localparam logic [AGE_W-1:0]  URG_A = AGE_W'(URG_AGE);

    logic              tick;
    logic              ackOk;
    logic              ovrSet;
    logic [DEBT_W-1:0] debtNxt;
    logic [AGE_W-1:0]  age;
    logic [AGE_W-1:0]  ageNxt;
    refState_t         state;
    refState_t         stateNxt;

    // Refresh interval tick source.
    ref_interval_timer #(
        .WIDTH  (TIMER_W),
        .RELOAD (INTERVAL - 1)
    ) uTimer (
        .CLK    (CLK),
        .nRST   (nRST),
        .En     (RefEn),
        .Tick_c (tick)
    );

    // An ack only counts while something is owed, so it is never applied twice.
    assign ackOk = RefAck && (Debt != '0);

    // Next debt, age and request level, all resolved before the outputs update.
    always_comb begin
        debtNxt  = Debt;
        ovrSet   = 1'b0;
        ageNxt   = '0;
        stateNxt = IDLE;

        case ({tick, ackOk})
            2'b10: begin
                if (Debt == MAX_D) begin
                    ovrSet = 1'b1;
                end else begin
                    debtNxt = Debt + DEBT_W'(1);
                end
            end
            2'b01:   debtNxt = Debt - DEBT_W'(1);
            default: debtNxt = Debt;
        endcase

        // Age measures the wait since the last service; state!=IDLE means Debt>0.
        if ((debtNxt == '0) || ackOk) begin
            ageNxt = '0;
        end else if (state != IDLE) begin
            ageNxt = (age >= URG_A) ? URG_A : age + AGE_W'(1);
        end

        stateNxt = classify(debtNxt, ageNxt, URG_D, URG_A);
    end

    // Debt/age/state registers with registered request outputs.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            Debt    <= '0;
            age     <= '0;
            state   <= IDLE;
            RefReq  <= 1'b0;
            RefUrg  <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            Debt    <= debtNxt;
            age     <= ageNxt;
            state   <= stateNxt;
            RefReq  <= (stateNxt != IDLE);
            RefUrg  <= (stateNxt == URG);
            if (ovrSet) begin
                Overrun <= 1'b1;
            end
        end
    end

`ifdef REF_STATS_EN
    // Service count and debt high-water mark.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            RefCount <= '0;
            MaxDebt  <= '0;
        end else begin
            if (ackOk) begin
                RefCount <= RefCount + STAT_W'(1);
            end
            if (debtNxt > MaxDebt) begin
                MaxDebt <= debtNxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_refresh_sched.sv
// Scoreboard bench for ram_refresh_sched: stimulus queues cycle-tagged
// expectations, a negedge monitor pops and compares them.
module tb_ram_refresh_sched;
    import ram_pkg::*;

    localparam int unsigned INTERVAL = 16;
    localparam int unsigned MAX_DEBT = 4;
    localparam int unsigned URG_DEBT = 2;
    localparam int unsigned URG_AGE  = 10;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              RefEn = 1'b0;
    logic              RefAck = 1'b0;
    logic              RefReq;
    logic              RefUrg;
    logic [DEBT_W-1:0] Debt;
    logic              Overrun;
`ifdef REF_STATS_EN
    logic [STAT_W-1:0] RefCount;
    logic [DEBT_W-1:0] MaxDebt;
`endif

    ram_refresh_sched #(
        .INTERVAL (INTERVAL),
        .MAX_DEBT (MAX_DEBT),
        .URG_DEBT (URG_DEBT),
        .URG_AGE  (URG_AGE)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .RefEn    (RefEn),
        .RefAck   (RefAck),
        .RefReq   (RefReq),
        .RefUrg   (RefUrg),
        .Debt     (Debt),
`ifdef REF_STATS_EN
        .Overrun  (Overrun),
        .RefCount (RefCount),
        .MaxDebt  (MaxDebt)
`else
        .Overrun  (Overrun)
`endif
    );

    always #5 CLK = ~CLK;

    // Cycle index since the most recent reset release.
    int cyc;
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int                cyc;
        bit                inRst;
        string             tag;
        logic              req;
        logic              urg;
        logic [DEBT_W-1:0] debt;
        logic              ovr;
    } exp_t;

    exp_t q[$];
    exp_t monE;
    int   nChecks = 0;
    int   nPass   = 0;

    task automatic expAt(input int c, input string tag, input logic req, input logic urg,
                         input logic [DEBT_W-1:0] d, input logic ovr);
        exp_t e;
        e.cyc = c; e.inRst = 1'b0; e.tag = tag;
        e.req = req; e.urg = urg; e.debt = d; e.ovr = ovr;
        q.push_back(e);
    endtask

    task automatic expRst(input string tag);
        exp_t e;
        e.cyc = 0; e.inRst = 1'b1; e.tag = tag;
        e.req = 1'b0; e.urg = 1'b0; e.debt = '0; e.ovr = 1'b0;
        q.push_back(e);
    endtask

    task automatic compare(input exp_t e);
        nChecks++;
        if (RefReq === e.req && RefUrg === e.urg && Debt === e.debt && Overrun === e.ovr) begin
            nPass++;
        end else begin
            $display("FAIL %s @cyc %0d: got req=%b urg=%b debt=%0d ovr=%b, want req=%b urg=%b debt=%0d ovr=%b",
                     e.tag, cyc, RefReq, RefUrg, Debt, Overrun, e.req, e.urg, e.debt, e.ovr);
        end
    endtask

    // Monitor: pops every expectation that falls due on this sample point.
    always @(negedge CLK) begin
        if (!nRST) begin
            while (q.size() > 0 && q[0].inRst) begin
                monE = q.pop_front();
                compare(monE);
            end
        end else begin
            while (q.size() > 0 && !q[0].inRst && q[0].cyc <= cyc) begin
                monE = q.pop_front();
                if (monE.cyc < cyc) begin
                    nChecks++;
                    $display("FAIL %s: due at cyc %0d, never sampled (now %0d)", monE.tag, monE.cyc, cyc);
                end else begin
                    compare(monE);
                end
            end
        end
    end

    task automatic waitCyc(input int n);
        int guard;
        guard = 0;
        do begin
            @(negedge CLK);
            guard++;
        end while (cyc != n && guard < 2000);
        if (cyc != n) begin
            $display("FAIL waitCyc: cyc %0d never reached (at %0d)", n, cyc);
            $fatal(1, "stimulus lost sync");
        end
    endtask

    // RefAck high for edges first..last inclusive.
    task automatic ackSpan(input int first, input int last);
        waitCyc(first - 1);
        RefAck = 1'b1;
        waitCyc(last);
        RefAck = 1'b0;
    endtask

    task automatic ackAt(input int n);
        ackSpan(n, n);
    endtask

    task automatic enAt(input int n, input logic v);
        waitCyc(n - 1);
        RefEn = v;
    endtask

    task automatic releaseRst();
        @(posedge CLK);
        #2 nRST = 1'b1;
    endtask

    task automatic hitReset(input string tag);
        expRst(tag);
        @(posedge CLK);
        #2 nRST = 1'b0;
        RefAck = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        expRst("por");
        repeat (3) @(negedge CLK);

        // Phase 1: free accrual, age escalation, debt saturation and overrun.
        RefEn = 1'b1;
        expAt(0,  "p1_start",    0, 0, 0, 0);
        expAt(15, "p1_pretick",  0, 0, 0, 0);
        expAt(16, "p1_firstreq", 1, 0, 1, 0);
        expAt(25, "p1_age9",     1, 0, 1, 0);
        expAt(26, "p1_age10urg", 1, 1, 1, 0);
        expAt(32, "p1_debt2",    1, 1, 2, 0);
        expAt(63, "p1_debt3",    1, 1, 3, 0);
        expAt(64, "p1_debt4",    1, 1, 4, 0);
        expAt(79, "p1_noovr",    1, 1, 4, 0);
        expAt(80, "p1_ovr",      1, 1, 4, 1);
        expAt(96, "p1_sat",      1, 1, 4, 1);
        releaseRst();
        waitCyc(97);
        hitReset("p1_asyncrst");

        // Phase 2: acks, tick+ack collision, RefEn hold and resume.
        RefEn = 1'b1;
        expAt(16,  "p2_pend",      1, 0, 1, 0);
        expAt(20,  "p2_preack",    1, 0, 1, 0);
        expAt(21,  "p2_ackidle",   0, 0, 0, 0);
        expAt(23,  "p2_ackzero",   0, 0, 0, 0);
        expAt(32,  "p2_pend2",     1, 0, 1, 0);
        expAt(41,  "p2_age9",      1, 0, 1, 0);
        expAt(42,  "p2_age10",     1, 1, 1, 0);
        expAt(48,  "p2_debt2",     1, 1, 2, 0);
        expAt(64,  "p2_tickack",   1, 1, 2, 0);
        expAt(65,  "p2_ackpend",   1, 0, 1, 0);
        expAt(74,  "p2_agereset",  1, 0, 1, 0);
        expAt(75,  "p2_ageurg",    1, 1, 1, 0);
        expAt(80,  "p2_debt2b",    1, 1, 2, 0);
        expAt(101, "p2_ackdisab",  1, 0, 1, 0);
        expAt(110, "p2_dis_age9",  1, 0, 1, 0);
        expAt(111, "p2_dis_urg",   1, 1, 1, 0);
        expAt(150, "p2_hold",      1, 1, 1, 0);
        expAt(195, "p2_pretick",   1, 1, 1, 0);
        expAt(196, "p2_resume",    1, 1, 2, 0);
        expAt(212, "p2_debt3",     1, 1, 3, 0);
        releaseRst();
        ackAt(21);
        ackAt(23);
        ackSpan(64, 65);
        enAt(91, 1'b0);
        ackAt(101);
        enAt(191, 1'b1);
        waitCyc(214);
        hitReset("p2_asyncrst");

        // Phase 3: single pending refresh ages into urgent, then one ack clears it.
        RefEn = 1'b1;
        expAt(16, "p3_pend",    1, 0, 1, 0);
        expAt(25, "p3_age9",    1, 0, 1, 0);
        expAt(26, "p3_urg",     1, 1, 1, 0);
        expAt(29, "p3_preack",  1, 1, 1, 0);
        expAt(30, "p3_cleared", 0, 0, 0, 0);
        expAt(40, "p3_quiet",   0, 0, 0, 0);
        releaseRst();
        enAt(17, 1'b0);
        ackAt(30);
        waitCyc(41);

        while (q.size() > 0) begin
            monE = q.pop_front();
            nChecks++;
            $display("FAIL %s: expectation left unchecked (due cyc %0d)", monE.tag, monE.cyc);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
